// File: rtl/trivium_pkg.sv
// Shared Trivium definitions: state geometry, tap positions, FSM states and the
// key/IV load mapping used by both the encryptor and the decryptor.
package trivium_pkg;

    localparam int unsigned STATE_W      = 288;
    localparam int unsigned WARMUP_STEPS = 1152;
    localparam int unsigned KEY_W        = 80;
    // Wide enough to hold 1152 warm-up cycles when DATA_W = 1.
    localparam int unsigned CNT_W        = 11;

    // Output taps.
    localparam int unsigned TAP_T1A = 65;
    localparam int unsigned TAP_T1B = 92;
    localparam int unsigned TAP_T2A = 161;
    localparam int unsigned TAP_T2B = 176;
    localparam int unsigned TAP_T3A = 242;
    localparam int unsigned TAP_T3B = 287;

    // Feedback taps: AND pair plus cross-register tap, one triple per register.
    localparam int unsigned TAP_A1 = 90;
    localparam int unsigned TAP_A2 = 91;
    localparam int unsigned TAP_A3 = 170;
    localparam int unsigned TAP_B1 = 174;
    localparam int unsigned TAP_B2 = 175;
    localparam int unsigned TAP_B3 = 263;
    localparam int unsigned TAP_C1 = 285;
    localparam int unsigned TAP_C2 = 286;
    localparam int unsigned TAP_C3 = 68;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWarm,
        StRun,
        StDrain
    } trivium_state_e;

    // S[79:0] = key, S[172:93] = iv, S[287:285] = 3'b111, all else zero.
    function automatic logic [STATE_W-1:0] trivium_load(input logic [KEY_W-1:0] key,
                                                        input logic [KEY_W-1:0] iv);
        return {3'b111, 112'b0, iv, 13'b0, key};
    endfunction

endpackage

// File: rtl/trivium_core_step.sv
// Purely combinational Trivium core: advances the 288-bit state by STEPS steps and
// returns the keystream bits produced, first bit in ks_o[STEPS-1].
module trivium_core_step
    import trivium_pkg::*;
#(
    parameter int unsigned STEPS = 8
) (
    input  logic [STATE_W-1:0] state_i,
    output logic [STATE_W-1:0] state_o,
    output logic [STEPS-1:0]   ks_o
);

    // Unrolled step chain; each iteration is one Trivium clock.
    always_comb begin
        logic [STATE_W-1:0] s;
        logic               t1;
        logic               t2;
        logic               t3;
        s    = state_i;
        ks_o = '0;
        t1   = 1'b0;
        t2   = 1'b0;
        t3   = 1'b0;
        for (int i = 0; i < STEPS; i++) begin
            t1 = s[TAP_T1A] ^ s[TAP_T1B];
            t2 = s[TAP_T2A] ^ s[TAP_T2B];
            t3 = s[TAP_T3A] ^ s[TAP_T3B];
            ks_o[STEPS-1-i] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[TAP_A1] & s[TAP_A2]) ^ s[TAP_A3];
            t2 = t2 ^ (s[TAP_B1] & s[TAP_B2]) ^ s[TAP_B3];
            t3 = t3 ^ (s[TAP_C1] & s[TAP_C2]) ^ s[TAP_C3];
            s  = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
        end
        state_o = s;
    end

endmodule

// File: rtl/trivium_decrypt.sv
// Streaming Trivium decryptor: load key/IV on start, 1152-step warm-up, then XOR each
// accepted ciphertext word with DATA_W keystream bits (MSB first) onto a valid/ready stream.
// Optional macro TRIVIUM_DEC_KS_OUT_EN adds a registered keystream debug output ks_data_o.
module trivium_decrypt
    import trivium_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
`ifdef TRIVIUM_DEC_KS_OUT_EN
    output logic [DATA_W-1:0] ks_data_o,
`endif
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [KEY_W-1:0]  key_i,
    input  logic [KEY_W-1:0]  iv_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o
);

    localparam logic [CNT_W-1:0] WarmCycles = CNT_W'(WARMUP_STEPS / DATA_W);

    trivium_state_e     fsm_q, fsm_d;
    logic [STATE_W-1:0] s_q, s_d, s_step;
    logic [DATA_W-1:0]  ks_step;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               done_q, done_d;
    logic               in_hs, out_hs;
`ifdef TRIVIUM_DEC_KS_OUT_EN
    logic [DATA_W-1:0]  ks_q, ks_d;
`endif

    trivium_core_step #(
        .STEPS (DATA_W)
    ) u_core (
        .state_i (s_q),
        .state_o (s_step),
        .ks_o    (ks_step)
    );

    // Accept input only in RUN when the output register is free or draining this cycle.
    assign in_ready_o = (fsm_q == StRun) && (!out_valid_q || out_ready_i);
    assign in_hs      = in_valid_i && in_ready_o;
    assign out_hs     = out_valid_q && out_ready_i;

    // Next-state: FSM sequencing, cipher state advance and output register update.
    always_comb begin
        fsm_d       = fsm_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
`ifdef TRIVIUM_DEC_KS_OUT_EN
        ks_d        = ks_q;
`endif
        if (out_hs) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        unique case (fsm_q)
            StIdle: begin
                // done_q high means this is the done cycle; a start here is dropped.
                if (start_i && !done_q) begin
                    s_d   = trivium_load(key_i, iv_i);
                    fsm_d = StLoad;
                end
            end
            StLoad: begin
                cnt_d = WarmCycles;
                fsm_d = StWarm;
            end
            StWarm: begin
                s_d   = s_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    fsm_d = StRun;
                end
            end
            StRun: begin
                if (in_hs) begin
                    s_d         = s_step;
                    out_valid_d = 1'b1;
                    out_data_d  = in_data_i ^ ks_step;
                    out_last_d  = in_last_i;
`ifdef TRIVIUM_DEC_KS_OUT_EN
                    ks_d        = ks_step;
`endif
                    if (in_last_i) begin
                        fsm_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (out_hs && out_last_q) begin
                    done_d = 1'b1;
                    fsm_d  = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    // State registers; reset discards any in-flight message.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            fsm_q       <= StIdle;
            s_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef TRIVIUM_DEC_KS_OUT_EN
            ks_q        <= '0;
`endif
        end else begin
            fsm_q       <= fsm_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
`ifdef TRIVIUM_DEC_KS_OUT_EN
            ks_q        <= ks_d;
`endif
        end
    end

    assign busy_o      = (fsm_q != StIdle);
    assign done_o      = done_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
`ifdef TRIVIUM_DEC_KS_OUT_EN
    assign ks_data_o   = ks_q;
`endif

endmodule

// File: tb/tb_trivium_decrypt.sv
// Bench for trivium_decrypt: bit-serial reference model in standard 1-indexed Trivium
// notation, a scoreboard monitor on the output stream, and directed message scenarios.
`timescale 1ns/1ps
module tb_trivium_decrypt;

    localparam int unsigned DW       = 8;
    localparam int unsigned NW       = 64;
    localparam int unsigned WARM_CYC = 1152 / DW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [79:0]   key, iv;
    logic          start;
    logic          busy, done;
    logic          in_valid, in_ready, in_last;
    logic [DW-1:0] in_data;
    logic          out_valid, out_ready, out_last;
    logic [DW-1:0] out_data;
`ifdef TRIVIUM_DEC_KS_OUT_EN
    logic [DW-1:0] ks_data;
`endif

    always #5 clk = ~clk;

    trivium_decrypt #(
        .DATA_W (DW)
    ) u_dut (
`ifdef TRIVIUM_DEC_KS_OUT_EN
        .ks_data_o   (ks_data),
`endif
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .key_i       (key),
        .iv_i        (iv),
        .start_i     (start),
        .busy_o      (busy),
        .done_o      (done),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: s1..s288 ----------------
    bit ms [1:288];

    function automatic void model_clear();
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
    endfunction

    function automatic void model_load(input logic [79:0] k, input logic [79:0] v);
        model_clear();
        for (int i = 0; i < 80; i++) begin
            ms[i + 1]  = k[i];
            ms[i + 94] = v[i];
        end
        ms[286] = 1'b1;
        ms[287] = 1'b1;
        ms[288] = 1'b1;
    endfunction

    function automatic bit model_step();
        bit z, t1, t2, t3;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 93; i >= 2; i--) ms[i] = ms[i-1];
        ms[1] = t3;
        for (int i = 177; i >= 95; i--) ms[i] = ms[i-1];
        ms[94] = t1;
        for (int i = 288; i >= 179; i--) ms[i] = ms[i-1];
        ms[178] = t2;
        return z;
    endfunction

    function automatic logic [DW-1:0] model_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW; i++) w[DW-1-i] = model_step();
        return w;
    endfunction

    function automatic logic [287:0] model_pack();
        logic [287:0] v;
        for (int i = 1; i <= 288; i++) v[i-1] = ms[i];
        return v;
    endfunction

    // ---------------- message scoreboard ----------------
    logic [DW-1:0] ct_a  [NW];
    logic [DW-1:0] exp_a [NW];
    logic [DW-1:0] ks_a  [NW];
    int            out_idx;
    bit            mon_en;
    bit            bp_en;
    bit            stall_prev;
    bit            done_pending;
    logic [DW-1:0] data_prev;

    // kind 0: all-zero ciphertext; kind 1: random plaintext encrypted by the model;
    // kind 2: random ciphertext.
    task automatic prepare(input logic [79:0] k, input logic [79:0] v, input int kind);
        logic [DW-1:0] pt;
        model_load(k, v);
        for (int i = 0; i < 1152; i++) void'(model_step());
        for (int w = 0; w < NW; w++) begin
            ks_a[w] = model_word();
            pt      = DW'($urandom);
            if (kind == 1) begin
                ct_a[w]  = pt ^ ks_a[w];
                exp_a[w] = pt;
            end else begin
                ct_a[w]  = (kind == 0) ? '0 : DW'($urandom);
                exp_a[w] = ct_a[w] ^ ks_a[w];
            end
        end
    endtask

    // Output backpressure, changed just after each active edge.
    always @(posedge clk) begin
        #1;
        out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare process: done pulse, stall stability and every output handshake.
    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            check("done_pulse", done, done_pending);
            if (done_pending) check("busy_at_done", busy, 1'b0);
            done_pending = 1'b0;
            if (stall_prev) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, data_prev);
            end
            if (out_valid && !out_ready) check("in_ready_stall", in_ready, 1'b0);
            if (out_valid && out_ready) begin
                if (out_idx < NW) begin
                    check("out_data", out_data, exp_a[out_idx]);
                    check("out_last", out_last, out_idx == NW - 1);
`ifdef TRIVIUM_DEC_KS_OUT_EN
                    check("ks_data", ks_data, ks_a[out_idx]);
`endif
                    if (out_idx == NW - 1) done_pending = 1'b1;
                end else begin
                    check("extra_word", out_idx + 1, NW);
                end
                out_idx++;
            end
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
        end else begin
            stall_prev   = 1'b0;
            done_pending = 1'b0;
        end
    end

    // Runs one full message; caller is 1 time unit after an active edge.
    task automatic run_msg(input logic [79:0] k, input logic [79:0] v, input int kind,
                           input bit mid_start, input bit done_start);
        int c, wi, rdy_cyc;
        prepare(k, v, kind);
        out_idx = 0;
        mon_en  = 1'b1;
        rdy_cyc = -1;
        wi      = 0;
        key     = k;
        iv      = v;
        for (c = 0; c < 3000 && !(wi == NW && out_idx == NW && !busy); c++) begin
            start    = (c == 0) ||
                       (mid_start && (c == 50 || c == int'(WARM_CYC) + 22));
            in_valid = (wi < NW) && (kind != 2 || $urandom_range(0, 3) != 0);
            in_data  = (wi < NW) ? ct_a[wi] : '0;
            in_last  = (wi == NW - 1);
            @(negedge clk);
            if (c == 0) check("busy_before_load", busy, 1'b0);
            if (c == 1) check("busy_in_load", busy, 1'b1);
            if (in_ready && rdy_cyc < 0) rdy_cyc = c;
            if (in_valid && in_ready) wi++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = done_start;
        check("in_ready_first_cycle", rdy_cyc, WARM_CYC + 2);
        check("words_in", wi, NW);
        check("words_out", out_idx, NW);
        @(negedge clk);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        if (done_start) begin
            @(negedge clk);
            check("start_on_done_ignored", busy, 1'b0);
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            check("start_after_done_taken", busy, 1'b1);
            reset_n = 1'b0;
            @(posedge clk);
            #1;
            reset_n = 1'b1;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_data"}, out_data, '0);
        check({tag, "_out_last"}, out_last, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [287:0] e;
        logic [95:0]  r1, r2;
        bit           z;
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        key      = '0;
        iv       = '0;
        mon_en   = 1'b0;
        bp_en    = 1'b0;
        out_idx  = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Hand-derived pins on the model itself.
        model_load('0, '0);
        check("pin_load_ks_e0", model_word(), 8'hE0);
        model_clear();
        ms[93] = 1'b1;
        z = model_step();
        e = '0;
        e[93] = 1'b1;
        check("pin_s92_z", z, 1'b1);
        check("pin_s92_state", model_pack(), e);
        model_clear();
        ms[91] = 1'b1;
        ms[92] = 1'b1;
        z = model_step();
        e = '0;
        e[91] = 1'b1;
        e[92] = 1'b1;
        e[93] = 1'b1;
        check("pin_and_z", z, 1'b0);
        check("pin_and_state", model_pack(), e);
        model_clear();
        ms[264] = 1'b1;
        z = model_step();
        e = '0;
        e[177] = 1'b1;
        e[264] = 1'b1;
        check("pin_s263_z", z, 1'b0);
        check("pin_s263_state", model_pack(), e);

        // Zero vector, then start on the done cycle (ignored) and the cycle after.
        run_msg('0, '0, 0, 1'b0, 1'b1);

        // Round trip with random key/iv.
        r1 = {$urandom, $urandom, $urandom};
        r2 = {$urandom, $urandom, $urandom};
        run_msg(r1[79:0], r2[79:0], 1, 1'b0, 1'b0);

        // Random backpressure and input gaps on the same key/iv.
        bp_en = 1'b1;
        run_msg(r1[79:0], r2[79:0], 2, 1'b0, 1'b0);
        bp_en = 1'b0;

        // Extra start pulses during warm-up and mid-RUN.
        run_msg(r2[79:0], r1[79:0], 1, 1'b1, 1'b0);

        // Reset during warm-up, then a fresh message.
        key   = r1[79:0] ^ 80'h5;
        iv    = '0;
        start = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (c == 79) check("busy_in_warm", busy, 1'b1);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midwarm");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_msg(r1[79:0] ^ 80'h5, 80'h1234_5678_9abc_def0_1357, 1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
